fatori_dmem_responder: RTL and testbench
========================================

Name: fatori_dmem_responder

Overview:
- Memory-side responder for the core's data bus; the other end of the data_req/gnt/rvalid protocol driven by the load-store unit.
- Holds a word-addressed, byte-writable RAM and grants requests against an outstanding-response limit.
- Returns in-order responses after a fixed latency and flags out-of-range accesses with a bus error.
- Used as the data-memory model in fault-tolerance benches and as the small on-chip scratchpad.

Parameters:
- DEPTH, 1024: RAM size in 32-bit words; power of two, >= 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.
- RESP_LAT, 1: cycles from the grant cycle to rvalid; 1..4.
- MAX_OUTST, 2: maximum granted-but-unanswered requests; 1..4.
- LFSR_SEED, 8'hA5: stall LFSR reset value; nonzero; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_req_i  in  1  request valid.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_we_i  in  1  1 = store, 0 = load.
- data_be_i  in  4  byte enables for stores.
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  request accepted this cycle; combinational.
- data_rvalid_o  out  1  response valid, one cycle per granted request.
- data_rdata_o  out  32  load data; 0 for stores and errors.
- data_err_o  out  1  bus error, qualified by rvalid.
- outst_o  out  3  current outstanding count, for debug.

Behaviour:
- Reset (async, rst_ni low): rvalid=0, rdata=0, err=0, outst=0, response pipe cleared, LFSR=LFSR_SEED. RAM contents are not reset.
- Grant: data_gnt_o = data_req_i & (outst < MAX_OUTST | retire_now) & ~stall.
  - retire_now = pipe head valid this cycle.
  - Grant is combinational, so the request is accepted in the same cycle.
- In range: BASE_ADDR <= addr < BASE_ADDR + DEPTH*4. Index = (addr - BASE_ADDR) >> 2, width $clog2(DEPTH).
- Granted store, in range: write the bytes selected by be at the grant clock edge. be=0 is a legal no-op store with a normal response.
- Granted load, in range: RAM read at grant. The read reflects all earlier granted stores, including one granted in the previous cycle.
- Out of range: no write; response err=1, rdata=0.
- Response pipe: RESP_LAT stages of {valid, err, rdata}.
  - Entered at the grant edge; output from the last stage.
  - With RESP_LAT=1: grant in cycle t gives rvalid in cycle t+1.
  - Responses are strictly in grant order. rdata=0 and err=0 whenever rvalid=0.
- outst: +1 on grant, -1 on rvalid; unchanged if both happen in the same cycle. It never exceeds MAX_OUTST.
- Back-pressure: there is no rready; the initiator must always accept rvalid. When outst = MAX_OUTST with no retire this cycle, gnt=0 while req stays high.
- The request is not latched before grant. The initiator holds addr/we/be/wdata stable until gnt.
- Reset mid-operation discards all pending responses. No rvalid follows reset release for requests granted before reset.
- When effective capacity (RESP_LAT vs MAX_OUTST) allows, back-to-back grants sustain one request per cycle.

Optional Feature:
- Macro: FATORI_DMEM_STALL_EN.
- With the macro:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, advances every cycle.
  - stall = (lfsr[1:0] == 2'b00), giving roughly 25% pseudo-random grant suppression.
  - Stalls delay grants only; responses are never delayed.
- Without the macro: stall tied to 0, the LFSR and LFSR_SEED logic are absent, and grant depends only on capacity.

Test Plan:
- Reset, then store addr=0x10, be=4'hF, wdata=0xDEADBEEF; load 0x10 next cycle (RESP_LAT=1) -> store gets rvalid, err=0, rdata=0; load gets rvalid with rdata=0xDEADBEEF.
- Store be=4'b0010, wdata=0x0000AB00 onto 0xDEADBEEF at 0x20, then load 0x20 -> rdata=0xDEADABEF.
- Load addr=BASE_ADDR+DEPTH*4 -> rvalid with err=1, rdata=0; RAM unchanged; a following in-range load still returns correct data.
- RESP_LAT=3, MAX_OUTST=2, req held high for 6 loads -> gnt pattern 1,1,0,1,1,0 (a new grant is allowed in the cycle the oldest response retires); outst never exceeds 2; rdata in address order.
- Two grants pending, assert rst_ni low for 1 cycle -> rvalid=0 through and after reset; outst=0; the next request is granted immediately.
- With FATORI_DMEM_STALL_EN, req held 64 cycles -> gnt=0 exactly in cycles where lfsr[1:0]=0 (checked against a reference LFSR from seed 0xA5); every grant produces exactly one rvalid.

Source files
------------

// File: rtl/fatori_dmem_responder.sv
// Data-memory responder: byte-writable word RAM behind a req/gnt/rvalid bus with fixed-latency in-order responses.
// Define FATORI_DMEM_STALL_EN to add LFSR-driven pseudo-random grant stalls.
module fatori_dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RESP_LAT  = 1,
    parameter int          MAX_OUTST = 2,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [2:0]  outst_o
);
    localparam int          AW   = $clog2(DEPTH);
    localparam int          LAST = RESP_LAT - 1;
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    logic [31:0]         ram_q [DEPTH];
    logic [31:0]         pdata_q [RESP_LAT];
    logic [RESP_LAT-1:0] pv_q, pv_d, perr_q, perr_d, pld_q, pld_d;
    logic [2:0]          outst_q, outst_d;
    logic [31:0]         offset;
    logic [AW-1:0]       idx;
    logic                in_range, gnt, retire_now, stall;
    logic                unused_addr_bits;

    // Subtracting the base first makes addresses below BASE_ADDR wrap high and fail the range test.
    assign offset           = data_addr_i - BASE_ADDR;
    assign in_range         = offset < SPAN;
    assign idx              = offset[AW+1:2];
    assign unused_addr_bits = ^{offset[1:0], (offset >> (AW + 2))};

`ifdef FATORI_DMEM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign stall  = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    // A retiring response frees its slot in the same cycle, so a full pipe can still accept.
    assign retire_now = pv_q[LAST];
    assign gnt        = data_req_i & ((outst_q < 3'(MAX_OUTST)) | retire_now) & ~stall;

    always_comb begin
        pv_d      = '0;
        perr_d    = '0;
        pld_d     = '0;
        pv_d[0]   = gnt;
        perr_d[0] = gnt & ~in_range;
        pld_d[0]  = gnt & ~data_we_i & in_range;
        for (int i = 1; i < RESP_LAT; i++) begin
            pv_d[i]   = pv_q[i-1];
            perr_d[i] = perr_q[i-1];
            pld_d[i]  = pld_q[i-1];
        end
        outst_d = outst_q + 3'(gnt) - 3'(retire_now);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv_q    <= '0;
            perr_q  <= '0;
            pld_q   <= '0;
            outst_q <= '0;
        end else begin
            pv_q    <= pv_d;
            perr_q  <= perr_d;
            pld_q   <= pld_d;
            outst_q <= outst_d;
        end
    end

    // RAM and read-data stages carry no reset; the flag pipe qualifies them at the output.
    always_ff @(posedge clk_i) begin
        if (gnt && in_range && data_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) ram_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
        end
        if (gnt) pdata_q[0] <= ram_q[idx];
        for (int i = 1; i < RESP_LAT; i++) pdata_q[i] <= pdata_q[i-1];
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = pv_q[LAST];
    assign data_err_o    = perr_q[LAST];
    assign data_rdata_o  = pld_q[LAST] ? pdata_q[LAST] : 32'h0;
    assign outst_o       = outst_q;
endmodule

// File: tb/tb_fatori_dmem_responder.sv
// Directed bench for fatori_dmem_responder: a RESP_LAT=1 instance for data paths and a RESP_LAT=3 instance for flow control.
// With FATORI_DMEM_STALL_EN defined, the grant stall pattern is checked against a reference LFSR instead.
module tb_fatori_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic [3:0]  a_be = '0;
    logic        a_gnt, a_rvalid, a_err;
    logic [31:0] a_rdata;
    logic [2:0]  a_outst;

    logic        b_req = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic [3:0]  b_be = 4'hF;
    logic        b_gnt, b_rvalid, b_err;
    logic [31:0] b_rdata;
    logic [2:0]  b_outst;

    fatori_dmem_responder #(.DEPTH(64), .BASE_ADDR(32'h0), .RESP_LAT(1), .MAX_OUTST(2)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(a_req), .data_addr_i(a_addr), .data_we_i(a_we),
        .data_be_i(a_be), .data_wdata_i(a_wdata), .data_gnt_o(a_gnt), .data_rvalid_o(a_rvalid),
        .data_rdata_o(a_rdata), .data_err_o(a_err), .outst_o(a_outst));

    fatori_dmem_responder #(.DEPTH(16), .BASE_ADDR(32'h1000), .RESP_LAT(3), .MAX_OUTST(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(b_req), .data_addr_i(b_addr), .data_we_i(b_we),
        .data_be_i(b_be), .data_wdata_i(b_wdata), .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid),
        .data_rdata_o(b_rdata), .data_err_o(b_err), .outst_o(b_outst));

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("  ok   %s = %h", tag, got);
        end
    endtask

    // Table for instance A: request driven in a cycle, and the response/outst seen in that same cycle.
    logic        ta_req   [13] = '{1,1,1,1,1,1,1,1,1,1,1,0,0};
    logic        ta_we    [13] = '{1,0,1,1,1,0,0,1,1,0,0,0,0};
    logic [31:0] ta_addr  [13] = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h20, 32'h20, 32'h100,
                                   32'h110, 32'hFC, 32'hFC, 32'h13, 32'h0, 32'h0};
    logic [3:0]  ta_be    [13] = '{4'hF, 4'h0, 4'hF, 4'h2, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [31:0] ta_wdata [13] = '{32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0000AB00, 32'h0, 32'h0, 32'h0,
                                   32'hFFFFFFFF, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        ta_rv    [13] = '{0,1,1,1,1,1,1,1,1,1,1,1,0};
    logic        ta_err   [13] = '{0,0,0,0,0,0,0,1,1,0,0,0,0};
    logic [31:0] ta_rdata [13] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hDEADABEF,
                                   32'h0, 32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF, 32'h0};
    logic [2:0]  ta_outst [13] = '{0,1,1,1,1,1,1,1,1,1,1,1,0};

    logic [31:0] b_words  [6] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002,
                                  32'hC0DE0003, 32'hC0DE0004, 32'hC0DE0005};
    logic        b_gpat   [8] = '{1,1,0,1,1,0,1,1};
    logic [2:0]  b_opat   [8] = '{0,1,2,2,2,2,2,2};

    // One transaction on instance B; reports grant wait, response latency after the grant edge, err and data.
    task automatic b_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output int gwait, output int lat, output logic err, output logic [31:0] rd);
        bit got;
        got = 0; gwait = -1; lat = -1; err = 1'b0; rd = '0;
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_be = 4'hF;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            if (b_gnt) begin got = 1; gwait = i; end
            @(posedge clk); @(negedge clk);
        end
        b_req = 1'b0;
        check("B gnt seen", 32'(got), 32'd1);
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            if (b_rvalid) begin got = 1; lat = i + 1; err = b_err; rd = b_rdata; end
            @(posedge clk); @(negedge clk);
        end
        check("B rvalid seen", 32'(got), 32'd1);
    endtask

    initial begin
        int          gw, lt, nrv;
        logic        e;
        logic [31:0] d;
        logic [31:0] rq[$];

        repeat (2) @(negedge clk);
        #1;
        check("rst A rvalid", 32'(a_rvalid), 32'd0);
        check("rst A rdata", a_rdata, 32'd0);
        check("rst A err", 32'(a_err), 32'd0);
        check("rst A outst", 32'(a_outst), 32'd0);
        check("rst B outst", 32'(b_outst), 32'd0);
        rst_n = 1'b1;

`ifdef FATORI_DMEM_STALL_EN
        begin
            logic [7:0] ref_lfsr;
            int ng, nr;
            ref_lfsr = 8'hA5; ng = 0; nr = 0;
            a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_be = 4'h0;
            for (int c = 0; c < 64; c++) begin
                #1;
                check($sformatf("stall c%0d gnt", c), 32'(a_gnt), 32'(ref_lfsr[1:0] != 2'b00));
                ng += int'(a_gnt);
                nr += int'(a_rvalid);
                @(posedge clk);
                ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
                @(negedge clk);
            end
            a_req = 1'b0;
            for (int c = 0; c < 4; c++) begin
                #1; nr += int'(a_rvalid);
                @(posedge clk); @(negedge clk);
            end
            check("stall grants==rvalids", 32'(nr), 32'(ng));
        end
`else
        for (int r = 0; r < 13; r++) begin
            a_req = ta_req[r]; a_we = ta_we[r]; a_addr = ta_addr[r]; a_be = ta_be[r]; a_wdata = ta_wdata[r];
            #1;
            check($sformatf("A%0d gnt", r), 32'(a_gnt), 32'(ta_req[r]));
            check($sformatf("A%0d rvalid", r), 32'(a_rvalid), 32'(ta_rv[r]));
            check($sformatf("A%0d err", r), 32'(a_err), 32'(ta_err[r]));
            check($sformatf("A%0d rdata", r), a_rdata, ta_rdata[r]);
            check($sformatf("A%0d outst", r), 32'(a_outst), 32'(ta_outst[r]));
            @(posedge clk); @(negedge clk);
        end

        for (int k = 0; k < 6; k++) begin
            b_txn(1'b1, 32'h1000 + 32'(4 * k), b_words[k], gw, lt, e, d);
            check($sformatf("B store%0d lat", k), 32'(lt), 32'd3);
        end

        // Held request stream of six loads against a two-deep outstanding limit.
        begin
            int k = 0;
            b_req = 1'b1; b_we = 1'b0; b_addr = 32'h1000;
            for (int c = 0; c < 8; c++) begin
                #1;
                check($sformatf("B burst c%0d gnt", c), 32'(b_gnt), 32'(b_gpat[c]));
                check($sformatf("B burst c%0d outst", c), 32'(b_outst), 32'(b_opat[c]));
                if (b_rvalid) rq.push_back(b_rdata);
                if (b_gnt) k++;
                @(posedge clk); @(negedge clk);
                b_addr = 32'h1000 + 32'(4 * k);
                if (k >= 6) b_req = 1'b0;
            end
            b_req = 1'b0;
            for (int c = 0; c < 8; c++) begin
                #1;
                if (b_rvalid) rq.push_back(b_rdata);
                @(posedge clk); @(negedge clk);
            end
            check("B burst resp count", 32'(rq.size()), 32'd6);
            for (int k2 = 0; k2 < 6 && k2 < rq.size(); k2++)
                check($sformatf("B burst rdata%0d", k2), rq[k2], b_words[k2]);
        end

        b_txn(1'b0, 32'h0FFC, 32'h0, gw, lt, e, d);
        check("B below-base err", 32'(e), 32'd1);
        check("B below-base rdata", d, 32'd0);
        b_txn(1'b0, 32'h1040, 32'h0, gw, lt, e, d);
        check("B above-top err", 32'(e), 32'd1);
        b_txn(1'b0, 32'h1014, 32'h0, gw, lt, e, d);
        check("B last word err", 32'(e), 32'd0);
        check("B last word rdata", d, 32'hC0DE0005);

        // Two loads in flight, then a one-cycle reset must drop both responses.
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h1000;
        #1; check("B pre-rst gnt0", 32'(b_gnt), 32'd1);
        @(posedge clk); @(negedge clk);
        b_addr = 32'h1004;
        #1; check("B pre-rst gnt1", 32'(b_gnt), 32'd1);
        @(posedge clk); @(negedge clk);
        b_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("B in-rst rvalid", 32'(b_rvalid), 32'd0);
        check("B in-rst outst", 32'(b_outst), 32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        nrv = 0;
        for (int c = 0; c < 6; c++) begin
            #1; nrv += int'(b_rvalid);
            @(posedge clk); @(negedge clk);
        end
        check("B post-rst stray rvalids", 32'(nrv), 32'd0);
        check("B post-rst outst", 32'(b_outst), 32'd0);
        b_txn(1'b0, 32'h1008, 32'h0, gw, lt, e, d);
        check("B post-rst gnt wait", 32'(gw), 32'd0);
        check("B post-rst lat", 32'(lt), 32'd3);
        check("B post-rst rdata", d, 32'hC0DE0002);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
